// File: rtl/instruction_pkg.sv
// Shared instruction encodings, ALU control codes and pipeline payload types for the integer execute unit.
package instruction_pkg;

    localparam int DATA_W    = 32;
    localparam int TAG_W     = 6;
    localparam int ROB_IDX_W = 5;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [2:0] F3_ADD  = 3'd0;
    localparam logic [2:0] F3_SLL  = 3'd1;
    localparam logic [2:0] F3_SLT  = 3'd2;
    localparam logic [2:0] F3_SLTU = 3'd3;
    localparam logic [2:0] F3_XOR  = 3'd4;
    localparam logic [2:0] F3_SRL  = 3'd5;
    localparam logic [2:0] F3_OR   = 3'd6;
    localparam logic [2:0] F3_AND  = 3'd7;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR,
        ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_PASS_B
    } alu_ctrl_e;

    typedef struct packed {
        alu_ctrl_e              ctrl;
        logic [DATA_W-1:0]      a;
        logic [DATA_W-1:0]      b;
        logic [TAG_W-1:0]       rd;
        logic [ROB_IDX_W-1:0]   rob;
    } s1_pay_t;

    typedef struct packed {
        logic [DATA_W-1:0]      result;
        logic [TAG_W-1:0]       rd;
        logic [ROB_IDX_W-1:0]   rob;
    } s2_pay_t;

    // alt is funct7[5]: selects SUB (register form only) and SRA (both forms)
    function automatic alu_ctrl_e decode_alu(input logic [6:0] opcode,
                                             input logic       alt,
                                             input logic [2:0] funct3);
        alu_ctrl_e c;
        c = ALU_ADD;
        if (opcode == OPC_LUI) begin
            c = ALU_PASS_B;
        end else if (opcode == OPC_OP || opcode == OPC_OP_IMM) begin
            case (funct3)
                F3_ADD:  c = (opcode == OPC_OP && alt) ? ALU_SUB : ALU_ADD;
                F3_SLL:  c = ALU_SLL;
                F3_SLT:  c = ALU_SLT;
                F3_SLTU: c = ALU_SLTU;
                F3_XOR:  c = ALU_XOR;
                F3_SRL:  c = alt ? ALU_SRA : ALU_SRL;
                F3_OR:   c = ALU_OR;
                F3_AND:  c = ALU_AND;
                default: c = ALU_ADD;
            endcase
        end
        return c;
    endfunction

endpackage

// File: rtl/alu_core.sv
// Purpose: combinational integer ALU between the decode and result stages.
// Latency: 0 cycles (pure logic).
// Backpressure: none; the surrounding pipeline registers hold operands stable.
module alu_core
    import instruction_pkg::*;
#(
    parameter int XLEN = DATA_W
) (
    input  alu_ctrl_e        ctrl,
    input  logic [XLEN-1:0]  a,
    input  logic [XLEN-1:0]  b,
    output logic [XLEN-1:0]  result
);

    logic [4:0] shamt;
    assign shamt = b[4:0];

    always_comb begin
        result = '0;
        case (ctrl)
            ALU_ADD:    result = a + b;
            ALU_SUB:    result = a - b;
            ALU_SLL:    result = a << shamt;
            ALU_SLT:    result = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
            ALU_SLTU:   result = {{(XLEN-1){1'b0}}, (a < b)};
            ALU_XOR:    result = a ^ b;
            ALU_SRL:    result = a >> shamt;
            ALU_SRA:    result = $signed(a) >>> shamt;
            ALU_OR:     result = a | b;
            ALU_AND:    result = a & b;
            ALU_PASS_B: result = b;
            default:    result = a + b;
        endcase
    end

endmodule

// File: rtl/alu_exec_unit.sv
// Purpose: two-stage integer execute unit (S1 decode/operand select, S2 result) feeding writeback.
// Latency: 2 cycles accept-to-wb_valid, one uop per cycle sustained.
// Backpressure: wb_ready low stalls S2, then S1; issue_ready drops only when both are full.
module alu_exec_unit
    import instruction_pkg::*;
#(
    parameter int XLEN   = DATA_W,
    parameter int PREG_W = TAG_W,
    parameter int ROB_W  = ROB_IDX_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              issue_valid,
    output logic              issue_ready,
    input  logic [6:0]        issue_opcode,
    input  logic [6:0]        issue_funct7,
    input  logic [2:0]        issue_funct3,
    input  logic [XLEN-1:0]   issue_rs1,
    input  logic [XLEN-1:0]   issue_rs2,
    input  logic [XLEN-1:0]   issue_imm,
    input  logic [XLEN-1:0]   issue_pc,
    input  logic [PREG_W-1:0] issue_rd,
    input  logic [ROB_W-1:0]  issue_rob,
    output logic              wb_valid,
    input  logic              wb_ready,
    output logic [XLEN-1:0]   wb_result,
    output logic [PREG_W-1:0] wb_rd,
    output logic [ROB_W-1:0]  wb_rob
);

    // Payload structs are sized by the package, so parameters must agree with it
    if (XLEN != DATA_W || PREG_W != TAG_W || ROB_W != ROB_IDX_W) begin : g_width_check
        $error("alu_exec_unit parameters must match instruction_pkg widths");
    end

    logic    s1_valid, s2_valid, s1_advance;
    s1_pay_t s1_q, s1_d;
    s2_pay_t s2_q;
    logic [XLEN-1:0] alu_result;

    logic unused_funct7;
    assign unused_funct7 = ^{issue_funct7[6], issue_funct7[4:0]};

    assign s1_advance  = !s2_valid || wb_ready;
    assign issue_ready = !s1_valid || s1_advance;

    always_comb begin
        s1_d      = '0;
        s1_d.ctrl = decode_alu(issue_opcode, issue_funct7[5], issue_funct3);
        s1_d.a    = (issue_opcode == OPC_AUIPC) ? issue_pc : issue_rs1;
        case (issue_opcode)
            OPC_OP_IMM, OPC_LUI, OPC_AUIPC: s1_d.b = issue_imm;
            default:                        s1_d.b = issue_rs2;
        endcase
        s1_d.rd   = issue_rd;
        s1_d.rob  = issue_rob;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
        end else if (flush) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
        end else begin
            if (s1_advance) s2_valid <= s1_valid;
            if (issue_ready) s1_valid <= issue_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (issue_ready && issue_valid) s1_q <= s1_d;
        if (s1_advance) begin
            s2_q.result <= alu_result;
            s2_q.rd     <= s1_q.rd;
            s2_q.rob    <= s1_q.rob;
        end
    end

    alu_core #(.XLEN(XLEN)) u_alu_core (
        .ctrl   (s1_q.ctrl),
        .a      (s1_q.a),
        .b      (s1_q.b),
        .result (alu_result)
    );

    assign wb_valid  = s2_valid;
    assign wb_result = s2_q.result;
    assign wb_rd     = s2_q.rd;
    assign wb_rob    = s2_q.rob;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Randomized plus directed bench for alu_exec_unit against a queue-based reference model.
module tb_alu_exec_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        issue_valid = 1'b0;
    logic        issue_ready;
    logic [6:0]  issue_opcode = '0;
    logic [6:0]  issue_funct7 = '0;
    logic [2:0]  issue_funct3 = '0;
    logic [31:0] issue_rs1 = '0, issue_rs2 = '0, issue_imm = '0, issue_pc = '0;
    logic [5:0]  issue_rd = '0;
    logic [4:0]  issue_rob = '0;
    logic        wb_valid;
    logic        wb_ready = 1'b0;
    logic [31:0] wb_result;
    logic [5:0]  wb_rd;
    logic [4:0]  wb_rob;

    always #5 clk = ~clk;

    alu_exec_unit #(.XLEN(32), .PREG_W(6), .ROB_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .issue_valid(issue_valid), .issue_ready(issue_ready),
        .issue_opcode(issue_opcode), .issue_funct7(issue_funct7), .issue_funct3(issue_funct3),
        .issue_rs1(issue_rs1), .issue_rs2(issue_rs2), .issue_imm(issue_imm), .issue_pc(issue_pc),
        .issue_rd(issue_rd), .issue_rob(issue_rob),
        .wb_valid(wb_valid), .wb_ready(wb_ready),
        .wb_result(wb_result), .wb_rd(wb_rd), .wb_rob(wb_rob)
    );

    typedef struct {
        logic [31:0] res;
        logic [5:0]  rd;
        logic [4:0]  rob;
        int          t;
    } exp_t;

    exp_t        q[$];
    int          n_tests = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          n_acc = 0;
    logic        have_exp = 1'b0;
    logic [31:0] exp_ovr = '0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // Result straight from the ISA rules
    function automatic logic [31:0] ref_result(input logic [6:0] op, input logic [6:0] f7,
                                               input logic [2:0] f3, input logic [31:0] rs1,
                                               input logic [31:0] rs2, input logic [31:0] imm,
                                               input logic [31:0] pc);
        logic [31:0] b;
        int sh;
        b = (op == 7'h13 || op == 7'h37 || op == 7'h17) ? imm : rs2;
        sh = int'(b % 32);
        if (op == 7'h37) return imm;
        if (op == 7'h17) return pc + imm;
        if (op != 7'h33 && op != 7'h13) return rs1 + b;
        case (f3)
            3'd0: return (op == 7'h33 && f7[5]) ? rs1 - b : rs1 + b;
            3'd1: return rs1 << sh;
            3'd2: return ($signed(rs1) < $signed(b)) ? 32'd1 : 32'd0;
            3'd3: return (rs1 < b) ? 32'd1 : 32'd0;
            3'd4: return rs1 ^ b;
            3'd5: return f7[5] ? 32'($signed(rs1) >>> sh) : rs1 >> sh;
            3'd6: return rs1 | b;
            default: return rs1 & b;
        endcase
    endfunction

    task automatic set_uop(input logic [6:0] op, input logic [6:0] f7, input logic [2:0] f3,
                           input logic [31:0] rs1, input logic [31:0] rs2,
                           input logic [31:0] imm, input logic [31:0] pc);
        issue_opcode = op;  issue_funct7 = f7;  issue_funct3 = f3;
        issue_rs1 = rs1;    issue_rs2 = rs2;    issue_imm = imm;  issue_pc = pc;
        issue_rd  = 6'($urandom);
        issue_rob = 5'($urandom);
    endtask

    task automatic rand_uop();
        logic [6:0] op;
        logic [6:0] f7;
        case ($urandom_range(0, 5))
            0, 1:    op = 7'h33;
            2, 3:    op = 7'h13;
            4:       op = ($urandom_range(0, 1) != 0) ? 7'h37 : 7'h17;
            default: op = 7'($urandom);
        endcase
        case ($urandom_range(0, 2))
            0:       f7 = 7'h00;
            1:       f7 = 7'h20;
            default: f7 = 7'($urandom);
        endcase
        set_uop(op, f7, 3'($urandom), $urandom, $urandom, $urandom, $urandom);
        have_exp = 1'b0;
    endtask

    // One clock: drive, check outputs against the model, then advance the model on the edge
    task automatic step(input logic v, input logic wr, input logic fl);
        logic exp_vld, exp_rdy, acc, wbh;
        exp_t e;
        issue_valid = v;  wb_ready = wr;  flush = fl;
        #1;
        exp_vld = (q.size() > 0) && (q[0].t <= cyc - 2);
        exp_rdy = (q.size() < 2) || wr;
        chk("wb_valid", 32'(wb_valid), 32'(exp_vld));
        chk("issue_ready", 32'(issue_ready), 32'(exp_rdy));
        if (exp_vld && wb_valid) begin
            chk("wb_result", wb_result, q[0].res);
            chk("wb_rd", 32'(wb_rd), 32'(q[0].rd));
            chk("wb_rob", 32'(wb_rob), 32'(q[0].rob));
        end
        acc = v && issue_ready;
        wbh = wb_valid && wr;
        e.res = have_exp ? exp_ovr
                         : ref_result(issue_opcode, issue_funct7, issue_funct3,
                                      issue_rs1, issue_rs2, issue_imm, issue_pc);
        e.rd = issue_rd;  e.rob = issue_rob;  e.t = cyc;
        @(posedge clk);
        if (wbh) void'(q.pop_front());
        if (fl) q.delete();
        else if (acc) begin
            q.push_back(e);
            n_acc++;
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic directed(input logic [6:0] op, input logic [6:0] f7, input logic [2:0] f3,
                            input logic [31:0] rs1, input logic [31:0] rs2,
                            input logic [31:0] imm, input logic [31:0] pc,
                            input logic [31:0] expected);
        set_uop(op, f7, f3, rs1, rs2, imm, pc);
        have_exp = 1'b1;
        exp_ovr  = expected;
        step(1'b1, 1'b1, 1'b0);
        have_exp = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0);
    endtask

    initial begin
        int acc0;
        @(negedge clk);
        chk("reset_wb_valid", 32'(wb_valid), 32'd0);
        chk("reset_issue_ready", 32'(issue_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        directed(7'h33, 7'h20, 3'd0, 32'd5, 32'd7, 32'd0, 32'd0, 32'hFFFF_FFFE);
        directed(7'h13, 7'h20, 3'd5, 32'h8000_0000, 32'd0, 32'h404, 32'd0, 32'hF800_0000);
        directed(7'h33, 7'h00, 3'd2, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, 32'd1);
        directed(7'h33, 7'h00, 3'd3, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, 32'd0);
        directed(7'h17, 7'h00, 3'd0, 32'd0, 32'd0, 32'h2000, 32'h1000, 32'h3000);
        directed(7'h37, 7'h00, 3'd0, 32'd9, 32'd0, 32'hABCD_E000, 32'd0, 32'hABCD_E000);
        drain();

        // 8 back-to-back uops
        for (int i = 0; i < 8; i++) begin
            rand_uop();
            step(1'b1, 1'b1, 1'b0);
        end
        drain();

        // Writeback stalled for 5 cycles while uops are offered
        acc0 = n_acc;
        rand_uop();
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b0, 1'b0);
            if (n_acc != acc0 + 1 && i == 0) rand_uop();
            if (i == 1) rand_uop();
        end
        chk("stall_accepts", 32'(n_acc - acc0), 32'd2);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0);
        drain();

        // Flush with both stages full and a third uop offered
        for (int i = 0; i < 2; i++) begin
            rand_uop();
            step(1'b1, 1'b0, 1'b0);
        end
        rand_uop();
        step(1'b1, 1'b0, 1'b1);
        drain();

        // Randomized traffic with occasional flush and mid-run reset
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                rst_n = 1'b0;
                #1;
                chk("midreset_wb_valid", 32'(wb_valid), 32'd0);
                chk("midreset_issue_ready", 32'(issue_ready), 32'd1);
                q.delete();
                @(negedge clk);
                rst_n = 1'b1;
            end
            rand_uop();
            step($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
                 $urandom_range(0, 31) == 0);
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_exec_unit.md
ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

Interface
REQ-001 Parameter XLEN, default 32, data path width.
REQ-002 Parameter PREG_W, default 6, physical register tag width.
REQ-003 Parameter ROB_W, default 5, ROB index width.
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 flush  input  1  pipeline flush (mispredict/exception), synchronous.
REQ-007 issue_valid  input  1  issue stage presents a uop.
REQ-008 issue_ready  output  1  unit accepts the uop this cycle.
REQ-009 issue_opcode / issue_funct7 / issue_funct3  input  7/7/3  instruction fields.
REQ-010 issue_rs1 / issue_rs2 / issue_imm / issue_pc  input  XLEN each  operands, sign-extended immediate, PC.
REQ-011 issue_rd / issue_rob  input  PREG_W / ROB_W  destination tag, ROB index.
REQ-012 wb_valid  output  1  result available for writeback/CDB.
REQ-013 wb_ready  input  1  writeback consumes result this cycle.
REQ-014 wb_result / wb_rd / wb_rob  output  XLEN / PREG_W / ROB_W  result and tags.

Function
REQ-015 Two registered stages: S1 (decode + operand select), S2 (result); accept-to-wb_valid latency exactly 2 cycles with no stall.
REQ-016 Transfer occurs on valid && ready; issue_ready = !s1_valid || s1_advance, where s1_advance = !s2_valid || wb_ready.
REQ-017 Full throughput: one uop per cycle sustained when wb_ready held high.
REQ-018 With wb_ready low, S2 holds result/tags stable; S1 then holds; issue_ready falls once both stages are full.
REQ-019 wb_valid/outputs SHALL not depend combinationally on issue_* inputs; issue_ready may depend on wb_ready.
REQ-020 Decode in S1: OP and OP_IMM map funct3 to ADD/SUB, SLL, SLT, SLTU, XOR, SRL/SRA, OR, AND; SUB only for OP with funct7[5]=1; SRA when funct7[5]=1 for either opcode.
REQ-021 Operand B = issue_rs2 for OP, issue_imm for OP_IMM, LUI, AUIPC.
REQ-022 LUI result = imm; AUIPC result = pc + imm; any other opcode yields ADD of rs1 and B (no trap).
REQ-023 Shifts use B[4:0] only; SLT signed, SLTU unsigned, result 0/1 zero-extended; add/sub wrap modulo 2^XLEN.
REQ-024 flush clears s1_valid and s2_valid at the next edge; a uop handshaked in the flush cycle is discarded; wb_valid is low the cycle after flush.
REQ-025 Simultaneous wb handshake and flush: the handshaked result is consumed; nothing remains.
REQ-026 issue_ready remains asserted during flush per REQ-016; accepted uop dropped per REQ-024.

Reset
REQ-027 rst_n low clears s1_valid, s2_valid immediately; wb_valid=0, issue_ready=1 while in reset.
REQ-028 Data/tag registers need no reset; wb_result/wb_rd/wb_rob are don't-care while wb_valid=0.
REQ-029 Reset mid-operation discards all in-flight uops; first accept possible on the first edge after release.

Structure
REQ-030 Opcode constants (OP, OP_IMM, LUI, AUIPC), funct3 codes and the 4-bit alu_control encoding live in instruction_pkg; no local redefinition.
REQ-031 One sub-module alu_core: combinational (alu_control, a, b) -> result, instantiated between S1 and S2.
REQ-032 Pipeline stage payload is a packed struct defined in instruction_pkg.

Verification
REQ-033 OP funct7=0x20 funct3=0, rs1=5, rs2=7, wb_ready=1 -> 2 cycles later wb_result=0xFFFFFFFE, tags echoed.
REQ-034 OP_IMM funct3=5 funct7=0x20, rs1=0x80000000, imm=0x404 -> wb_result=0xF8000000 (shamt 4 only).
REQ-035 Back-to-back 8 uops, wb_ready=1 -> 8 results on consecutive cycles, in order.
REQ-036 wb_ready=0 for 5 cycles with 3 uops offered -> 2 accepted, issue_ready=0, wb outputs stable; release -> both delivered in order, third accepted.
REQ-037 Both stages full, flush pulse with issue_valid=1 -> wb_valid=0 next cycle, no results ever emitted for those 3 uops.
REQ-038 SLT rs1=0xFFFFFFFF rs2=1 -> 1; SLTU same -> 0; AUIPC pc=0x1000 imm=0x2000 -> 0x3000.
